// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone memory arbiter.
// Holds arbiter FSM states, grant encoding and policy selectors.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/arb_pick2.sv
// Two-requester combinational pick: fixed (req1 wins) or round robin.
// Ports: req0/req1 requests, last_grant, mode (1=RR) -> valid, winner.
module arb_pick2
    import wb_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    input  logic mode,
    output logic valid,
    output logic winner
);

    assign valid = req0 | req1;

    always_comb begin
        winner = GNT_M0;
        unique case (1'b1)
            (req0 & req1):  winner = mode ? ~last_grant : GNT_M1;
            (req1 & ~req0): winner = GNT_M1;
            (req0 & ~req1): winner = GNT_M0;
            default:        winner = GNT_M0;
        endcase
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Shares one Wishbone-classic slave between m0 (fetch) and m1 (load/store).
// Ports: clk_i, n_rst_i, m0_*/m1_* master sides, s_* slave side.
// Optional WB_ARB_TIMEOUT_EN adds an ack watchdog driving m*_err_o.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ARB_MODE       = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    n_rst_i,

    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH-1:0]   m0_data_i,
    output logic [DATA_WIDTH-1:0]   m0_data_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,

    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH-1:0]   m1_data_i,
    output logic [DATA_WIDTH-1:0]   m1_data_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,

    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic [DATA_WIDTH-1:0]   s_data_o,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    input  logic                    s_ack_i
);

    arb_state_e state_q;
    logic       last_q;
    logic       req0;
    logic       req1;
    logic       pick_valid;
    logic       pick_winner;
    logic       gnt0;
    logic       gnt1;
    logic       wd_hit;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

    arb_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_q),
        .mode       (ARB_MODE == ARB_RR),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;

    // An ack arriving on the limit cycle still completes normally.
    assign wd_hit = (state_q != IDLE)
                  & (wd_q == WD_W'(TIMEOUT_CYCLES))
                  & ~s_ack_i;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            wd_q <= '0;
        end else if (state_q == IDLE) begin
            wd_q <= '0;
        end else if (!s_ack_i && !wd_hit) begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    assign m0_err_o = gnt0 & m0_cyc_i & wd_hit;
    assign m1_err_o = gnt1 & m1_cyc_i & wd_hit;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wd_hit   = 1'b0;
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

    // Slave side is a pure mux of the granted master; idle drives zeros.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_addr_o = '0;
        s_data_o = '0;
        unique case (1'b1)
            gnt0: begin
                s_cyc_o  = m0_cyc_i & ~wd_hit;
                s_stb_o  = m0_stb_i & ~wd_hit;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_addr_o = m0_addr_i;
                s_data_o = m0_data_i;
            end
            gnt1: begin
                s_cyc_o  = m1_cyc_i & ~wd_hit;
                s_stb_o  = m1_stb_i & ~wd_hit;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_addr_o = m1_addr_i;
                s_data_o = m1_data_i;
            end
            default: ;
        endcase
    end

    // Gating by cyc_i keeps an ack coincident with an abort away from the master.
    assign m0_ack_o  = s_ack_i & gnt0 & m0_cyc_i;
    assign m1_ack_o  = s_ack_i & gnt1 & m1_cyc_i;
    assign m0_data_o = gnt0 ? s_data_i : '0;
    assign m1_data_o = gnt1 ? s_data_i : '0;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= IDLE;
            last_q  <= GNT_M1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= (pick_winner == GNT_M1) ? GNT1 : GNT0;
                    end
                end
                GNT0: begin
                    if (!m0_cyc_i) begin
                        state_q <= IDLE;
                    end else if (s_ack_i || wd_hit) begin
                        state_q <= IDLE;
                        last_q  <= GNT_M0;
                    end
                end
                GNT1: begin
                    if (!m1_cyc_i) begin
                        state_q <= IDLE;
                    end else if (s_ack_i || wd_hit) begin
                        state_q <= IDLE;
                        last_q  <= GNT_M1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter (round-robin and fixed instances).
// Honours WB_ARB_TIMEOUT_EN when the design is built with it.
module tb_wb_mem_arbiter;

    logic        clk = 1'b0;
    logic        n_rst;

    logic        m0_cyc, m0_stb, m0_we;
    logic [3:0]  m0_sel;
    logic [31:0] m0_addr, m0_wdat;
    logic        m1_cyc, m1_stb, m1_we;
    logic [3:0]  m1_sel;
    logic [31:0] m1_addr, m1_wdat;

    logic        auto_rr;
    logic        ack_man;
    logic [31:0] data_man;
    logic        ackq_rr = 1'b0;
    logic        ackq_fx = 1'b0;
    logic        s_ack_rr;
    logic        s_ack_fx;

    logic [31:0] rr_m0_data, rr_m1_data, fx_m0_data, fx_m1_data;
    logic        rr_m0_ack, rr_m0_err, rr_m1_ack, rr_m1_err;
    logic        fx_m0_ack, fx_m0_err, fx_m1_ack, fx_m1_err;
    logic        rr_s_cyc, rr_s_stb, rr_s_we;
    logic        fx_s_cyc, fx_s_stb, fx_s_we;
    logic [3:0]  rr_s_sel, fx_s_sel;
    logic [31:0] rr_s_addr, rr_s_data, fx_s_addr, fx_s_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Zero-wait-state-plus-one slave: acks the second cycle of each grant.
    always @(posedge clk) begin
        ackq_rr <= rr_s_cyc & rr_s_stb & ~ackq_rr;
        ackq_fx <= fx_s_cyc & fx_s_stb & ~ackq_fx;
    end

    assign s_ack_rr = auto_rr ? ackq_rr : ack_man;
    assign s_ack_fx = ackq_fx;

    wb_mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .ARB_MODE(1), .TIMEOUT_CYCLES(8)
    ) dut_rr (
        .clk_i(clk), .n_rst_i(n_rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
        .m0_sel_i(m0_sel), .m0_addr_i(m0_addr), .m0_data_i(m0_wdat),
        .m0_data_o(rr_m0_data), .m0_ack_o(rr_m0_ack), .m0_err_o(rr_m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
        .m1_sel_i(m1_sel), .m1_addr_i(m1_addr), .m1_data_i(m1_wdat),
        .m1_data_o(rr_m1_data), .m1_ack_o(rr_m1_ack), .m1_err_o(rr_m1_err),
        .s_cyc_o(rr_s_cyc), .s_stb_o(rr_s_stb), .s_we_o(rr_s_we),
        .s_sel_o(rr_s_sel), .s_addr_o(rr_s_addr), .s_data_o(rr_s_data),
        .s_data_i(data_man), .s_ack_i(s_ack_rr)
    );

    wb_mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .ARB_MODE(0), .TIMEOUT_CYCLES(8)
    ) dut_fx (
        .clk_i(clk), .n_rst_i(n_rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
        .m0_sel_i(m0_sel), .m0_addr_i(m0_addr), .m0_data_i(m0_wdat),
        .m0_data_o(fx_m0_data), .m0_ack_o(fx_m0_ack), .m0_err_o(fx_m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
        .m1_sel_i(m1_sel), .m1_addr_i(m1_addr), .m1_data_i(m1_wdat),
        .m1_data_o(fx_m1_data), .m1_ack_o(fx_m1_ack), .m1_err_o(fx_m1_err),
        .s_cyc_o(fx_s_cyc), .s_stb_o(fx_s_stb), .s_we_o(fx_s_we),
        .s_sel_o(fx_s_sel), .s_addr_o(fx_s_addr), .s_data_o(fx_s_data),
        .s_data_i(32'h0), .s_ack_i(s_ack_fx)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m0_req(input logic on, input logic [31:0] a);
        m0_cyc = on; m0_stb = on; m0_we = 1'b0;
        m0_sel = 4'hf; m0_addr = a; m0_wdat = 32'h0;
    endtask

    task automatic m1_req(input logic on, input logic [31:0] a);
        m1_cyc = on; m1_stb = on; m1_we = 1'b0;
        m1_sel = 4'hf; m1_addr = a; m1_wdat = 32'h0;
    endtask

    int          gq[$];
    logic [31:0] dq[$];

    initial begin
        int   last_ack;
        logic prev_cyc;
        int   fx_acks;
        logic got;
        logic lost;
        logic errs;

        n_rst = 1'b0;
        auto_rr = 1'b0;
        ack_man = 1'b1;
        data_man = 32'hCAFE_F00D;
        m0_req(1'b1, 32'h8);
        m1_req(1'b0, 32'h0);

        // Reset state: requests and a stray ack must not leak through.
        repeat (3) @(negedge clk);
        chk("rst_s_cyc", {31'b0, rr_s_cyc}, 0);
        chk("rst_s_stb", {31'b0, rr_s_stb}, 0);
        chk("rst_m0_ack", {31'b0, rr_m0_ack}, 0);
        chk("rst_m1_ack", {31'b0, rr_m1_ack}, 0);
        chk("rst_m0_data", rr_m0_data, 0);
        chk("rst_m0_err", {31'b0, rr_m0_err}, 0);

        // Contention: both masters request continuously.
        ack_man = 1'b0;
        auto_rr = 1'b1;
        m0_req(1'b1, 32'h100);
        m1_req(1'b1, 32'h200);
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) gq.push_back(i % 2);
        last_ack = -1;
        prev_cyc = 1'b0;
        fx_acks = 0;
        for (int t = 0; t < 40 && gq.size() > 0; t++) begin
            @(negedge clk);
            if (t == 0) chk("req_to_slave", {31'b0, rr_s_cyc}, 1);
            if (rr_s_cyc && !prev_cyc && last_ack >= 0)
                chk("rr_gap", t - last_ack, 2);
            if (rr_m0_ack || rr_m1_ack) begin
                chk("rr_order", {31'b0, rr_m1_ack}, gq.pop_front());
                last_ack = t;
            end
            if (fx_m0_ack || fx_m1_ack) begin
                chk("fx_tie", {31'b0, fx_m1_ack}, 1);
                fx_acks++;
            end
            prev_cyc = rr_s_cyc;
        end
        chk("rr_done", gq.size(), 0);
        chk("fx_acks_seen", {31'b0, fx_acks >= 2}, 1);

        // Fixed mode: m0 served once m1 goes quiet.
        m1_req(1'b0, 32'h0);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (fx_m0_ack) got = 1'b1;
        end
        chk("fx_m0_served", {31'b0, got}, 1);
        m0_req(1'b0, 32'h0);
        auto_rr = 1'b0;
        ack_man = 1'b0;
        repeat (4) @(negedge clk);

        // Single m0 read.
        m0_req(1'b1, 32'h10);
        dq.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        chk("rd_addr", rr_s_addr, 32'h10);
        chk("rd_cyc", {31'b0, rr_s_cyc}, 1);
        chk("rd_no_early_ack", {31'b0, rr_m0_ack}, 0);
        @(negedge clk);
        ack_man = 1'b1;
        data_man = 32'hDEAD_BEEF;
        #1;
        chk("rd_ack", {31'b0, rr_m0_ack}, 1);
        chk("rd_data", rr_m0_data, dq.pop_front());
        chk("rd_m1_ack", {31'b0, rr_m1_ack}, 0);
        chk("rd_m1_data", rr_m1_data, 0);
        @(negedge clk);
        chk("bubble_cyc", {31'b0, rr_s_cyc}, 0);
        chk("stray_ack", {31'b0, rr_m0_ack}, 0);
        chk("idle_data", rr_m0_data, 0);
        m0_req(1'b0, 32'h0);
        ack_man = 1'b0;
        @(negedge clk);

        // m1 write aborted with a coincident slave ack.
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
        m1_sel = 4'b0011; m1_addr = 32'h20; m1_wdat = 32'hA5A5_0000;
        @(negedge clk);
        chk("wr_we", {31'b0, rr_s_we}, 1);
        chk("wr_sel", {28'b0, rr_s_sel}, 32'h3);
        chk("wr_data", rr_s_data, 32'hA5A5_0000);
        chk("wr_addr", rr_s_addr, 32'h20);
        m1_cyc = 1'b0; m1_stb = 1'b0;
        ack_man = 1'b1;
        #1;
        chk("abort_no_ack", {31'b0, rr_m1_ack}, 0);
        chk("abort_cyc", {31'b0, rr_s_cyc}, 0);
        @(negedge clk);
        chk("abort_idle_ack", {31'b0, rr_m1_ack}, 0);
        ack_man = 1'b0;
        m0_req(1'b1, 32'h30);
        @(negedge clk);
        chk("post_abort_cyc", {31'b0, rr_s_cyc}, 1);
        chk("post_abort_addr", rr_s_addr, 32'h30);
        m0_req(1'b0, 32'h0);
        @(negedge clk);
        chk("m0_abort_cyc", {31'b0, rr_s_cyc}, 0);

        // Reset mid-transaction in GNT1.
        m1_req(1'b1, 32'h50);
        @(negedge clk);
        ack_man = 1'b1;
        #1;
        chk("pre_rst_ack", {31'b0, rr_m1_ack}, 1);
        #2 n_rst = 1'b0;
        #1;
        chk("async_cyc", {31'b0, rr_s_cyc}, 0);
        chk("async_stb", {31'b0, rr_s_stb}, 0);
        chk("async_ack", {31'b0, rr_m1_ack}, 0);
        chk("async_data", rr_m1_data, 0);
        ack_man = 1'b0;
        m0_req(1'b1, 32'h40);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("rst_tie_cyc", {31'b0, rr_s_cyc}, 1);
        chk("rst_tie_m0", rr_s_addr, 32'h40);
        ack_man = 1'b1;
        #1;
        chk("rst_tie_ack", {31'b0, rr_m0_ack}, 1);
        @(negedge clk);
        m0_req(1'b0, 32'h0);
        m1_req(1'b0, 32'h0);
        ack_man = 1'b0;
        repeat (3) @(negedge clk);

        // Slave never acks.
        m0_req(1'b1, 32'h60);
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("wd_err", {31'b0, rr_m0_err}, {31'b0, k == 8});
            chk("wd_cyc", {31'b0, rr_s_cyc}, {31'b0, k < 8});
            chk("wd_no_ack", {31'b0, rr_m0_ack}, 0);
        end
`else
        lost = 1'b0;
        errs = 1'b0;
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            if (!rr_s_cyc) lost = 1'b1;
            errs = errs | rr_m0_err | rr_m1_err;
        end
        chk("hold_cyc", {31'b0, lost}, 0);
        chk("hold_no_err", {31'b0, errs}, 0);
        chk("hold_addr", rr_s_addr, 32'h60);
`endif
        m0_req(1'b0, 32'h0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
